// File: rtl/core_run_ctrl.sv
// Run controller for a small core: loads a 32-word program image, boots the core,
// runs it until the halt instruction, a cycle limit or an abort, then freezes it.
module core_run_ctrl #(
  parameter logic [31:0] HALT_INST = 32'h0000006F,
  parameter int unsigned LIMIT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [4:0]         wr_addr,
  input  logic [31:0]        wr_data,
  input  logic               wr_last,
  input  logic [LIMIT_W-1:0] run_limit,
  input  logic [31:0]        core_inst,
  output logic [1023:0]      load_ins,
  output logic               core_reset,
  output logic               core_clk_en,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [LIMIT_W-1:0] cycles
);

  typedef enum logic [2:0] {StIdle, StLoad, StBoot, StRun, StHalt} state_e;

  state_e               state_q;
  logic                 boot_cnt_q;
  logic                 timeout_q;
  logic [LIMIT_W-1:0]   limit_q;
  logic [LIMIT_W-1:0]   cycles_q;
  logic [1023:0]        load_ins_q;
  logic [LIMIT_W-1:0]   cycles_inc;
  logic                 halt_hit;
  logic                 limit_hit;

  // Saturating count so an unlimited run never wraps back to a small value.
  assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + LIMIT_W'(1);
  assign halt_hit   = (core_inst == HALT_INST);
  assign limit_hit  = (limit_q != '0) && (cycles_inc == limit_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      boot_cnt_q <= 1'b0;
      timeout_q  <= 1'b0;
      limit_q    <= '0;
      cycles_q   <= '0;
      load_ins_q <= '0;
    end else if (abort) begin
      state_q   <= StIdle;
      timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) state_q <= StLoad;
        end
        StLoad: begin
          if (wr_valid) begin
            load_ins_q[{wr_addr, 5'd0} +: 32] <= wr_data;
            if (wr_last) begin
              state_q    <= StBoot;
              boot_cnt_q <= 1'b0;
              cycles_q   <= '0;
              timeout_q  <= 1'b0;
              limit_q    <= run_limit;
            end
          end
        end
        StBoot: begin
          if (boot_cnt_q) state_q <= StRun;
          else            boot_cnt_q <= 1'b1;
        end
        StRun: begin
          cycles_q <= cycles_inc;
          // Halt instruction wins a tie with the limit, so timeout stays low.
          if (halt_hit) begin
            state_q   <= StHalt;
            timeout_q <= 1'b0;
          end else if (limit_hit) begin
            state_q   <= StHalt;
            timeout_q <= 1'b1;
          end
        end
        StHalt: begin
          if (start) state_q <= StLoad;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Moore outputs decoded from the registered state only.
  assign wr_ready    = (state_q == StLoad);
  assign core_reset  = (state_q == StIdle) || (state_q == StLoad) || (state_q == StBoot);
  assign core_clk_en = (state_q == StBoot) || (state_q == StRun);
  assign busy        = (state_q == StLoad) || (state_q == StBoot) || (state_q == StRun);
  assign done        = (state_q == StHalt);
  assign timeout     = timeout_q;
  assign cycles      = cycles_q;
  assign load_ins    = load_ins_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed scenarios plus randomized programs, checked
// against run lengths and image contents predicted from a word-array model.
module tb_core_run_ctrl;
  localparam logic [31:0] HALT = 32'h0000006F;
  localparam int LW = 16;

  logic          clk, reset, start, abort, wr_valid, wr_ready, wr_last;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data, core_inst;
  logic [LW-1:0] run_limit, cycles;
  logic [1023:0] load_ins;
  logic          core_reset, core_clk_en, busy, done, timeout;

  logic [31:0] img [32];
  logic [31:0] pw [32];
  logic [4:0]  pa [32];
  int n_run, n_fail;

  core_run_ctrl #(.HALT_INST(HALT), .LIMIT_W(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .run_limit(run_limit), .core_inst(core_inst), .load_ins(load_ins),
    .core_reset(core_reset), .core_clk_en(core_clk_en), .busy(busy), .done(done),
    .timeout(timeout), .cycles(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {wr_ready, core_reset, core_clk_en, busy, done, timeout}
  function automatic logic [5:0] status();
    return {wr_ready, core_reset, core_clk_en, busy, done, timeout};
  endfunction

  function automatic logic [1023:0] img_vec();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[32*i +: 32] = img[i];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 32; i++) img[i] = 32'h0;
  endtask

  // Starts from IDLE or HALT, loads n words, leaves the controller in its first RUN cycle.
  task automatic load_prog(input int n, input logic [LW-1:0] limit, input bit gaps);
    start = 1'b1;
    run_limit = limit;
    step();
    start = 1'b0;
    n_run++;
    if (status() >> 1 !== 6'b011010) begin
      n_fail++;
      $display("FAIL load_entry: status got %b want 11010x", status());
    end
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        wr_valid = 1'b0; wr_addr = 5'($urandom); wr_data = $urandom; wr_last = 1'b1;
        step();
      end
      wr_valid = 1'b1; wr_addr = pa[i]; wr_data = pw[i]; wr_last = (i == n - 1);
      step();
      img[pa[i]] = pw[i];
    end
    wr_valid = 1'b0;
    wr_last = 1'b0;
    run_limit = LW'($urandom);  // must not affect the run just booted
    for (int b = 0; b < 2; b++) begin
      n_run++;
      if (status() !== 6'b011100 || cycles !== '0) begin
        n_fail++;
        $display("FAIL boot%0d: status got %b cycles %0d want 011100 cycles 0",
                 b, status(), cycles);
      end
      step();
    end
  endtask

  // Runs to HALT feeding core_inst from the image; compares against predicted length.
  task automatic run_check(input logic [LW-1:0] limit, input string name);
    int halt_at, len, k;
    bit to;
    halt_at = -1;
    for (int i = 31; i >= 0; i--) if (img[i] == HALT) halt_at = i;
    if (halt_at < 0 || (limit != 0 && int'(limit) < halt_at + 1)) begin
      len = int'(limit); to = 1'b1;
    end else begin
      len = halt_at + 1; to = 1'b0;
    end
    for (k = 0; k < 300; k++) begin
      n_run++;
      if (status() !== 6'b001100) begin
        n_fail++;
        $display("FAIL %s run%0d: status got %b want 001100", name, k, status());
      end
      core_inst = (k < 32) ? img[k] : 32'h00000013;
      start = 1'($urandom_range(0, 1));
      step();
      if (done) break;
    end
    start = 1'b0;
    core_inst = 32'h0;
    n_run++;
    if (k + 1 !== len || cycles !== LW'(len) || status() !== {5'b00001, to}) begin
      n_fail++;
      $display("FAIL %s end: len %0d cycles %0d status %b want len %0d status 00001%0d",
               name, k + 1, cycles, status(), len, to);
    end
    n_run++;
    if (load_ins !== img_vec()) begin
      n_fail++;
      $display("FAIL %s image: got %h want %h", name, load_ins, img_vec());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_img();
    n_run++;
    if (status() !== 6'b010000 || load_ins !== '0 || cycles !== '0) begin
      n_fail++;
      $display("FAIL reset: status %b cycles %0d want 010000 cycles 0", status(), cycles);
    end
  endtask

  task automatic test_basic();
    pw[0] = 32'h00100093; pa[0] = 5'd0;
    pw[1] = 32'h00208113; pa[1] = 5'd1;
    pw[2] = HALT;         pa[2] = 5'd2;
    load_prog(3, 16'd100, 1'b0);
    run_check(16'd100, "basic");
  endtask

  task automatic test_timeout();
    test_reset();
    pw[0] = 32'h00000013; pa[0] = 5'd0;
    load_prog(1, 16'd5, 1'b0);
    run_check(16'd5, "timeout");
  endtask

  task automatic test_ignore_wr();
    abort = 1'b1;
    step();
    abort = 1'b0;
    wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; wr_last = 1'b1;
    step();
    wr_valid = 1'b0; wr_last = 1'b0;
    n_run++;
    if (status() !== 6'b010000 || load_ins[32*7 +: 32] !== 32'h0) begin
      n_fail++;
      $display("FAIL ignore_wr: status %b word7 %h want 010000 word7 0",
               status(), load_ins[32*7 +: 32]);
    end
    pw[0] = 32'h00000013; pa[0] = 5'd0;
    pw[1] = 32'h12345678; pa[1] = 5'd7;
    pw[2] = HALT;         pa[2] = 5'd8;
    load_prog(3, 16'd0, 1'b0);
    run_check(16'd0, "ignore_wr_run");
  endtask

  task automatic test_abort();
    for (int i = 0; i < 4; i++) begin pw[i] = 32'h00000013; pa[i] = 5'(i); end
    load_prog(4, 16'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      core_inst = img[k];
      abort = (k == 2);
      start = 1'b1;
      step();
    end
    abort = 1'b0; start = 1'b0;
    n_run++;
    if (status() !== 6'b010000 || load_ins !== img_vec()) begin
      n_fail++;
      $display("FAIL abort: status %b want 010000", status());
    end
    pw[0] = HALT; pa[0] = 5'd1;
    load_prog(1, 16'd10, 1'b0);
    run_check(16'd10, "abort_reload");
  endtask

  task automatic test_reset_mid_load();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 5'(i + 10); wr_data = $urandom; wr_last = 1'b0;
      step();
    end
    wr_last = 1'b1; start = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; start = 1'b0;
    clear_img();
    n_run++;
    if (status() !== 6'b010000 || load_ins !== '0 || cycles !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_load: status %b cycles %0d want 010000 cycles 0",
               status(), cycles);
    end
  endtask

  task automatic test_tie();
    for (int i = 0; i < 3; i++) begin pw[i] = 32'h00000013; pa[i] = 5'(i); end
    pw[3] = HALT; pa[3] = 5'd3;
    load_prog(4, 16'd4, 1'b0);
    run_check(16'd4, "tie");
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int n;
      logic [LW-1:0] lim;
      n = $urandom_range(1, 6);
      lim = LW'($urandom_range(0, 40));
      for (int i = 0; i < n; i++) begin
        pa[i] = 5'($urandom);
        pw[i] = $urandom;
        if (pw[i] == HALT) pw[i] = 32'h00000013;
      end
      if (lim == 0 || $urandom_range(0, 1) == 1) pw[n-1] = HALT;
      // A stray write while halted must not land in the image.
      wr_valid = 1'b1; wr_addr = 5'($urandom); wr_data = $urandom; wr_last = 1'b1;
      step();
      wr_valid = 1'b0; wr_last = 1'b0;
      load_prog(n, lim, 1'b1);
      run_check(lim, "random");
    end
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
    wr_addr = '0; wr_data = '0; run_limit = '0; core_inst = '0;
    clear_img();
    test_reset();
    test_basic();
    test_timeout();
    test_ignore_wr();
    test_abort();
    test_reset_mid_load();
    test_tie();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
